mem_cache_ctrl: RTL
===================

Name: mem_cache_ctrl

Overview:
Direct-mapped, write-through, read-allocate data cache between the MEM stage and the SRAM controller. Serves read hits in the same cycle with no stall. Read misses and all writes go to the SRAM controller over a request/ready handshake, and the block holds `freeze` high until that transaction completes. Feeds the SRAM controller's request inputs and consumes its read data.

Parameters:
- `INDEX_W`, 6: index bits; number of sets = 2^INDEX_W.
- `ADDR_W`, 18: word-aligned SRAM byte-address width; tag width = ADDR_W-2-INDEX_W.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `addr`  in  32  MEM-stage byte address; only `addr[ADDR_W-1:2]` is used.
- `data_in`  in  32  MEM-stage store data.
- `MEM_R_en`  in  1  load request.
- `MEM_W_en`  in  1  store request.
- `data_out`  out  32  load result.
- `freeze`  out  1  pipeline stall.
- `sram_addr`  out  ADDR_W  request address to SRAM controller, low 2 bits forced to 0.
- `sram_wdata`  out  32  store data to SRAM controller.
- `sram_r_en`  out  1  read request, held until `sram_ready`.
- `sram_w_en`  out  1  write request, held until `sram_ready`.
- `sram_rdata`  in  32  read data, valid when `sram_ready`=1.
- `sram_ready`  in  1  one-cycle completion pulse from SRAM controller.

Behaviour:
- Address fields:
  - index = `addr[INDEX_W+1:2]`.
  - tag = `addr[ADDR_W-1:INDEX_W+2]`.
  - hit = valid[index] && tag_mem[index]==tag.
- Request priority: if `MEM_R_en` and `MEM_W_en` are both 1, the access is a write; the read is ignored.
- Reset:
  - State goes to IDLE; all valid bits clear.
  - `sram_r_en`=`sram_w_en`=0, `freeze`=0, `data_out`=0.
  - Tag and data arrays are not cleared.
  - Reset mid-transaction abandons it; any later `sram_ready` is ignored in IDLE.
- States:
  - IDLE
    - No request: `freeze`=0, `data_out`=0.
    - Read hit: `data_out`=data_mem[index] combinationally, `freeze`=0, stay IDLE.
    - Read miss: `freeze`=1 combinationally; latch addr; go RD_WAIT.
    - Write (hit or miss): `freeze`=1; latch addr and `data_in`; go WR_WAIT.
  - RD_WAIT
    - Outputs: `sram_r_en`=1, `sram_addr`=latched address, `freeze`=1.
    - On `sram_ready`: write data_mem/tag_mem[index], set valid[index], capture `sram_rdata` into a result register, go DONE.
  - WR_WAIT
    - Outputs: `sram_w_en`=1, `sram_wdata`=latched data, `freeze`=1.
    - On `sram_ready`: if the latched address hits, update data_mem[index]; a write miss does not allocate. Go DONE.
  - DONE
    - Exactly one cycle; `freeze`=0.
    - `data_out`=result register after a read, 0 after a write.
    - MEM inputs are ignored this cycle because the pipeline register still holds the same instruction.
    - Next state is IDLE unconditionally.
- Latency:
  - Read hit: 0 cycles.
  - Miss or write: 1 (IDLE) + N (wait, N ≥ 1) + 1 (DONE) cycles, where N is the cycle count until `sram_ready`.
- Handshake:
  - `sram_r_en` and `sram_w_en` are never both 1.
  - Request signals stay stable from assertion until the `sram_ready` cycle.
  - Both deassert in the cycle after `sram_ready`.
  - `sram_ready` outside a WAIT state is ignored.
- `sram_addr` and `sram_wdata` are registered copies of the latched request, so they do not glitch with the MEM-stage inputs.

Decomposition:
- Shared package `mem_cache_pkg`:
  - State enum (IDLE, RD_WAIT, WR_WAIT, DONE).
  - Default `INDEX_W`/`ADDR_W` constants.
  - Tag/index width functions.
- One sub-module, `cache_store`: valid/tag/data arrays with a combinational read port, one synchronous write port and synchronous valid-clear on `rst`.
- The controller FSM stays in `mem_cache_ctrl`.

Test Plan:
- Cold read miss:
  - Stimulus: after reset, `MEM_R_en`=1, addr=0x0000_0104; model returns 0xDEAD_BEEF after 3 cycles.
  - Required: `freeze`=1 for 4 cycles; `sram_addr`=0x104 held throughout; in DONE, `data_out`=0xDEAD_BEEF and `freeze`=0.
- Read hit: repeat the read of 0x104 → `data_out`=0xDEAD_BEEF in the same cycle, `freeze`=0, no `sram_r_en`.
- Write hit then read:
  - Stimulus: write 0x1234_5678 to 0x104 (model ready after 2 cycles), then read 0x104.
  - Required: `sram_w_en` held 2 cycles with `sram_wdata`=0x1234_5678; the read hits and returns 0x1234_5678.
- Conflict miss:
  - Stimulus: read 0x104 (cached), then read 0x204 (same index, different tag; model returns 0xCAFE_0001), then read 0x104 again.
  - Required: 0x204 misses and returns 0xCAFE_0001; 0x104 then misses again.
- Write miss: write 0x308 → SRAM write issued; a following read of 0x308 misses (no allocate).
- Reset and priority:
  - Stimulus: assert `rst` mid RD_WAIT, then send a late `sram_ready` pulse; also drive `MEM_R_en`=`MEM_W_en`=1.
  - Required: enables drop next cycle; the late ready is ignored; the previously hit line now misses. Both-enables request issues a write only.

Source files
------------

// File: rtl/mem_cache_pkg.sv
// Shared definitions for the MEM-stage write-through data cache:
// controller states, default geometry and field-width helpers.
package mem_cache_pkg;

  localparam int unsigned DEF_INDEX_W = 6;
  localparam int unsigned DEF_ADDR_W  = 18;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WR_WAIT,
    S_DONE
  } state_e;

  function automatic int unsigned tag_width(input int unsigned addr_w,
                                            input int unsigned index_w);
    return addr_w - 2 - index_w;
  endfunction

  function automatic int unsigned num_sets(input int unsigned index_w);
    return 1 << index_w;
  endfunction

endpackage

// File: rtl/cache_store.sv
// Direct-mapped valid/tag/data arrays: combinational lookup port, one
// synchronous write port that allocates a line, valid bits cleared on reset.
module cache_store
  import mem_cache_pkg::*;
#(
  parameter int unsigned INDEX_W = DEF_INDEX_W,
  parameter int unsigned TAG_W   = tag_width(DEF_ADDR_W, DEF_INDEX_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_idx_i,
  input  logic [TAG_W-1:0]   rd_tag_i,
  output logic               rd_hit_o,
  output logic [31:0]        rd_data_o,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [31:0]        wr_data_i
);

  localparam int unsigned NSETS = num_sets(INDEX_W);

  logic [NSETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [NSETS];
  logic [31:0]      data_q [NSETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data contents survive reset; only the valid bits gate hits.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_hit_o  = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/mem_cache_ctrl.sv
// Write-through, read-allocate cache controller between the MEM stage and
// the SRAM controller; read hits return in-cycle, everything else freezes.
module mem_cache_ctrl
  import mem_cache_pkg::*;
#(
  parameter int unsigned INDEX_W = DEF_INDEX_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [31:0]       data_in,
  input  logic              MEM_R_en,
  input  logic              MEM_W_en,
  output logic [31:0]       data_out,
  output logic              freeze,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_r_en,
  output logic              sram_w_en,
  input  logic [31:0]       sram_rdata,
  input  logic              sram_ready
);

  localparam int unsigned TAG_W  = tag_width(ADDR_W, INDEX_W);
  localparam int unsigned WORD_W = ADDR_W - 2;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       result_q, result_d;

  logic [WORD_W-1:0] look_addr;
  logic              hit;
  logic [31:0]       line_data;
  logic              st_we;
  logic [31:0]       st_wdata;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{addr[31:ADDR_W], addr[1:0]};

  // Outside IDLE the lookup uses the latched address, so the write-hit
  // decision in WR_WAIT is independent of the live MEM-stage inputs.
  assign look_addr = (state_q == S_IDLE) ? addr[ADDR_W-1:2] : waddr_q;

  cache_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .rd_idx_i  (look_addr[INDEX_W-1:0]),
    .rd_tag_i  (look_addr[WORD_W-1:INDEX_W]),
    .rd_hit_o  (hit),
    .rd_data_o (line_data),
    .we_i      (st_we),
    .wr_idx_i  (waddr_q[INDEX_W-1:0]),
    .wr_tag_i  (waddr_q[WORD_W-1:INDEX_W]),
    .wr_data_i (st_wdata)
  );

  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    result_d = result_q;
    freeze   = 1'b0;
    data_out = '0;
    st_we    = 1'b0;
    st_wdata = sram_rdata;
    unique case (state_q)
      S_IDLE: begin
        if (MEM_W_en) begin
          freeze   = 1'b1;
          waddr_d  = addr[ADDR_W-1:2];
          wdata_d  = data_in;
          result_d = '0;
          state_d  = S_WR_WAIT;
        end else if (MEM_R_en) begin
          if (hit) begin
            data_out = line_data;
          end else begin
            freeze  = 1'b1;
            waddr_d = addr[ADDR_W-1:2];
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        freeze = 1'b1;
        if (sram_ready) begin
          st_we    = !rst;
          result_d = sram_rdata;
          state_d  = S_DONE;
        end
      end
      S_WR_WAIT: begin
        freeze = 1'b1;
        if (sram_ready) begin
          st_we    = hit && !rst;
          st_wdata = wdata_q;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        data_out = result_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      waddr_q  <= '0;
      wdata_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
    end
  end

  assign sram_r_en  = (state_q == S_RD_WAIT);
  assign sram_w_en  = (state_q == S_WR_WAIT);
  assign sram_addr  = {waddr_q, 2'b00};
  assign sram_wdata = wdata_q;

endmodule
